// File: rtl/delivery_velocity_sensor.sv
// Ultrasonic echo-width velocity sensor: trigger pulse, echo measurement, level quantisation.
// Optional build macro DELIVERY_VELOCITY_INVERT_EN reports velocity as 7 - level.
module delivery_velocity_sensor #(
  parameter int unsigned TRIGGER_CYCLES = 500,
  parameter int unsigned LEVEL_CYCLES   = 29000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       get_velocity,
  input  logic       echo,
  output logic       trigger,
  output logic [2:0] velocity,
  output logic       velocity_ready,
  output logic       busy,
  output logic       timeout_err,
  output logic [3:0] estado
);

  localparam int unsigned TRIG_W = $clog2(TRIGGER_CYCLES + 1);
  localparam int unsigned SUB_W  = $clog2(LEVEL_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    TRIGGER   = 4'd1,
    WAIT_ECHO = 4'd2,
    MEASURE   = 4'd3,
    DONE      = 4'd4,
    TIMEOUT   = 4'd5
  } state_t;

  state_t            state, next_state;
  logic              echo_meta, echo_sync;
  logic [TRIG_W-1:0] trig_cnt;
  logic [SUB_W-1:0]  sub_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [2:0]        level;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_meta <= 1'b0;
      echo_sync <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state     = IDLE;
    trigger        = 1'b0;
    velocity_ready = 1'b0;
    busy           = (state != IDLE);
    estado         = state;
    case (state)
      IDLE:      next_state = get_velocity ? TRIGGER : IDLE;
      TRIGGER: begin
        trigger    = 1'b1;
        next_state = (trig_cnt == TRIG_W'(TRIGGER_CYCLES - 1)) ? WAIT_ECHO : TRIGGER;
      end
      WAIT_ECHO: begin
        if (echo_sync)                                 next_state = MEASURE;
        else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1))  next_state = TIMEOUT;
        else                                           next_state = WAIT_ECHO;
      end
      MEASURE: begin
        if (!echo_sync)                                next_state = DONE;
        else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1))  next_state = TIMEOUT;
        else                                           next_state = MEASURE;
      end
      DONE:      velocity_ready = 1'b1;
      TIMEOUT:   velocity_ready = 1'b1;
      default:   next_state = IDLE;
    endcase
  end

  // The timeout counter restarts on the WAIT_ECHO->MEASURE edge so each state gets its own budget.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_cnt    <= '0;
      sub_cnt     <= '0;
      to_cnt      <= '0;
      level       <= '0;
      velocity    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (get_velocity) begin
            trig_cnt <= '0;
            sub_cnt  <= '0;
            to_cnt   <= '0;
            level    <= '0;
          end
        end
        TRIGGER:   trig_cnt <= trig_cnt + TRIG_W'(1);
        WAIT_ECHO: begin
          if (echo_sync) to_cnt <= '0;
          else           to_cnt <= to_cnt + TO_W'(1);
        end
        MEASURE: begin
          if (echo_sync) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (sub_cnt == SUB_W'(LEVEL_CYCLES - 1)) begin
              sub_cnt <= '0;
              if (level != 3'd7) level <= level + 3'd1;
            end else begin
              sub_cnt <= sub_cnt + SUB_W'(1);
            end
          end
        end
        DONE: begin
`ifdef DELIVERY_VELOCITY_INVERT_EN
          velocity <= 3'd7 - level;
`else
          velocity <= level;
`endif
          timeout_err <= 1'b0;
        end
        TIMEOUT:   timeout_err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delivery_velocity_sensor.sv
// Directed bench for delivery_velocity_sensor with small timing parameters.
module tb_delivery_velocity_sensor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       get_velocity = 1'b0;
  logic       echo = 1'b0;
  logic       trigger;
  logic [2:0] velocity;
  logic       velocity_ready;
  logic       busy;
  logic       timeout_err;
  logic [3:0] estado;

  int checks = 0;
  int failures = 0;

`ifdef DELIVERY_VELOCITY_INVERT_EN
  localparam logic [2:0] EXP35 = 3'd4;
  localparam logic [2:0] EXP75 = 3'd0;
`else
  localparam logic [2:0] EXP35 = 3'd3;
  localparam logic [2:0] EXP75 = 3'd7;
`endif

  delivery_velocity_sensor #(
    .TRIGGER_CYCLES(4),
    .LEVEL_CYCLES(10),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .get_velocity(get_velocity),
    .echo(echo),
    .trigger(trigger),
    .velocity(velocity),
    .velocity_ready(velocity_ready),
    .busy(busy),
    .timeout_err(timeout_err),
    .estado(estado)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one request; echo rises once trigger has fallen and stays high for width clocks.
  task automatic run_req(input int width, input bit poke,
                         output int trig_n, output int wait_n, output int meas_n,
                         output int rdy_n, output bit busy_at_rdy, output bit busy_after);
    int  echo_left;
    bit  trig_seen;
    int  post;
    trig_n = 0; wait_n = 0; meas_n = 0; rdy_n = 0;
    busy_at_rdy = 1'b0; busy_after = 1'b1;
    echo_left = -1; trig_seen = 1'b0; post = 0;
    get_velocity = 1'b1;
    step();
    get_velocity = 1'b0;
    for (int cyc = 0; cyc < 1000 && post < 20; cyc++) begin
      if (trigger) begin
        trig_n++;
        trig_seen = 1'b1;
      end else if (trig_seen && echo_left < 0) begin
        echo_left = width;
      end
      if (estado == 4'd2) wait_n++;
      if (estado == 4'd3) meas_n++;
      get_velocity = poke && (estado == 4'd3) && (meas_n == 10);
      if (echo_left > 0) begin
        echo = 1'b1;
        echo_left--;
      end else begin
        echo = 1'b0;
      end
      if (rdy_n > 0) post++;
      if (velocity_ready) begin
        rdy_n++;
        if (rdy_n == 1) busy_at_rdy = busy;
      end
      if (rdy_n > 0 && post == 1) busy_after = busy;
      step();
    end
    echo = 1'b0;
    get_velocity = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    get_velocity = 1'b1;
    step();
    step();
    checks++; if (estado !== 4'd0) begin failures++; $display("FAIL reset_estado got=%0d exp=0", estado); end
    checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL reset_trigger got=%b exp=0", trigger); end
    checks++; if (velocity !== 3'd0) begin failures++; $display("FAIL reset_velocity got=%0d exp=0", velocity); end
    checks++; if (velocity_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", velocity_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    get_velocity = 1'b0;
    reset = 1'b0;
    step();
    checks++; if (estado !== 4'd0) begin failures++; $display("FAIL reset_release_estado got=%0d exp=0", estado); end
  endtask

  task automatic test_basic();
    int t, w, m, r;
    bit br, ba;
    run_req(35, 1'b0, t, w, m, r, br, ba);
    checks++; if (t !== 4) begin failures++; $display("FAIL basic_trigger_width got=%0d exp=4", t); end
    checks++; if (r !== 1) begin failures++; $display("FAIL basic_ready_count got=%0d exp=1", r); end
    checks++; if (m !== 35) begin failures++; $display("FAIL basic_measure_cycles got=%0d exp=35", m); end
    checks++; if (velocity !== EXP35) begin failures++; $display("FAIL basic_velocity got=%0d exp=%0d", velocity, EXP35); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL basic_timeout_err got=%b exp=0", timeout_err); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", ba); end
  endtask

  task automatic test_measure_timeout();
    int t, w, m, r;
    bit br, ba;
    run_req(200, 1'b0, t, w, m, r, br, ba);
    checks++; if (m !== 100) begin failures++; $display("FAIL mto_measure_cycles got=%0d exp=100", m); end
    checks++; if (r !== 1) begin failures++; $display("FAIL mto_ready_count got=%0d exp=1", r); end
    checks++; if (velocity !== EXP35) begin failures++; $display("FAIL mto_velocity_held got=%0d exp=%0d", velocity, EXP35); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL mto_timeout_err got=%b exp=1", timeout_err); end
  endtask

  task automatic test_wait_timeout();
    int t, w, m, r;
    bit br, ba;
    run_req(0, 1'b0, t, w, m, r, br, ba);
    checks++; if (w !== 100) begin failures++; $display("FAIL wto_wait_cycles got=%0d exp=100", w); end
    checks++; if (r !== 1) begin failures++; $display("FAIL wto_ready_count got=%0d exp=1", r); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL wto_timeout_err got=%b exp=1", timeout_err); end
    checks++; if (velocity !== EXP35) begin failures++; $display("FAIL wto_velocity_held got=%0d exp=%0d", velocity, EXP35); end
    run_req(75, 1'b0, t, w, m, r, br, ba);
    checks++; if (velocity !== EXP75) begin failures++; $display("FAIL sat_velocity got=%0d exp=%0d", velocity, EXP75); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL sat_timeout_err got=%b exp=0", timeout_err); end
  endtask

  task automatic test_back_to_back();
    int t, w, m, r;
    bit br, ba;
    run_req(35, 1'b1, t, w, m, r, br, ba);
    checks++; if (r !== 1) begin failures++; $display("FAIL b2b_ready_count got=%0d exp=1", r); end
    checks++; if (br !== 1'b1) begin failures++; $display("FAIL b2b_busy_at_ready got=%b exp=1", br); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL b2b_busy_after got=%b exp=0", ba); end
    checks++; if (velocity !== EXP35) begin failures++; $display("FAIL b2b_velocity got=%0d exp=%0d", velocity, EXP35); end
  endtask

  task automatic test_reset_mid();
    int  rdy_n;
    int  bad;
    bit  reached;
    rdy_n = 0; bad = 0; reached = 1'b0;
    get_velocity = 1'b1;
    step();
    get_velocity = 1'b0;
    for (int cyc = 0; cyc < 60 && !reached; cyc++) begin
      if (estado == 4'd2) echo = 1'b1;
      if (estado == 4'd3) reached = 1'b1;
      if (velocity_ready) rdy_n++;
      step();
    end
    checks++; if (reached !== 1'b1) begin failures++; $display("FAIL rst_mid_reach_measure got=%b exp=1", reached); end
    for (int i = 0; i < 5; i++) begin
      if (velocity_ready) rdy_n++;
      step();
    end
    reset = 1'b1;
    #1;
    checks++; if (estado !== 4'd0) begin failures++; $display("FAIL rst_mid_estado got=%0d exp=0", estado); end
    checks++; if ({trigger, velocity, velocity_ready, busy, timeout_err} !== 7'd0)
      begin failures++; $display("FAIL rst_mid_outputs got=%b exp=0000000", {trigger, velocity, velocity_ready, busy, timeout_err}); end
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (velocity_ready) rdy_n++;
      if (estado != 4'd0 || trigger) bad++;
    end
    checks++; if (rdy_n !== 0) begin failures++; $display("FAIL rst_mid_no_ready got=%0d exp=0", rdy_n); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rst_mid_echo_ignored got=%0d exp=0", bad); end
    echo = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_measure_timeout();
    test_wait_timeout();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
